convolution_ctrl: RTL and testbench

- Sequencer for the discrete convolution datapath: z[i] = sum over j of x[j]*y[i-j].
- On start, it computes the output length Nx+Ny-1, then walks an outer index i and an inner index j.
- It drives read addresses for the x and y sample memories, accumulate-enable and clear strobes for the MAC, and a write strobe plus address for the z result memory.
- It sits between the host/config logic (start, sizes) and the memory/MAC datapath.

---
 rtl/conv_pkg.sv | 19 +
 rtl/conv_strobe_delay.sv | 27 ++
 rtl/convolution_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_convolution_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Purpose : shared types and limits for the convolution sequencer.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETUP,
    INNER,
    DRAIN,
    WRITE,
    DONE
  } conv_state_t;

  // Deepest x/y memory read latency the MAC strobe delay line supports.
  localparam int MEM_LAT_MAX = 4;

endpackage

// File: rtl/conv_strobe_delay.sv
// Purpose : DEPTH-stage shift register carrying {acc_en, acc_clr} to the MAC.
// Latency : exactly DEPTH cycles from i_strb_dat to o_strb_dat.
// Backpressure: none; shifts every cycle, all stages cleared by async reset.
// Ports: clk, rstn (async active-low), i_strb_dat {en,clr} in, o_strb_dat {en,clr} out.
module conv_strobe_delay #(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] i_strb_dat,
  output logic [1:0] o_strb_dat
);

  logic [1:0] r_stage [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < DEPTH; k++) r_stage[k] <= 2'b00;
    end else begin
      r_stage[0] <= i_strb_dat;
      for (int k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
    end
  end

  assign o_strb_dat = r_stage[DEPTH-1];

endmodule

// File: rtl/convolution_ctrl.sv
// Purpose : sequences z[i] = sum_j x[j]*y[i-j]: x/y reads, MAC strobes, z writes.
// Latency : per output sample 1 SETUP + (j_max-j_min+1) INNER + MEM_LAT DRAIN + 1 WRITE cycles.
// Backpressure: none; runs free once started, start_i only sampled in IDLE.
// Ports: clk, rstn; start_i, size_x_i, size_y_i from host; busy_o, done_o status;
//        addr_x_o, addr_y_o, rd_en_o to x/y memories; mac_clr_o, mac_en_o to MAC;
//        wr_z_o, addr_z_o to z memory. All outputs are registered.
module convolution_ctrl
  import conv_pkg::*;
#(
  parameter int DATAWIDTH = 5,
  parameter int MEM_LAT   = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start_i,
  input  logic [DATAWIDTH-1:0] size_x_i,
  input  logic [DATAWIDTH-1:0] size_y_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [DATAWIDTH-1:0] addr_x_o,
  output logic [DATAWIDTH-1:0] addr_y_o,
  output logic                 rd_en_o,
  output logic                 mac_clr_o,
  output logic                 mac_en_o,
  output logic                 wr_z_o,
  output logic [DATAWIDTH:0]   addr_z_o
);

  localparam int AW = DATAWIDTH + 1;
  localparam int CW = $clog2(MEM_LAT_MAX);

  conv_state_t          r_state, w_state_nxt;
  logic [DATAWIDTH-1:0] r_nx, r_ny, w_nx_nxt, w_ny_nxt;
  logic [AW-1:0]        r_out_len, r_i, r_j, r_jmax;
  logic [AW-1:0]        w_out_len_nxt, w_i_nxt, w_j_nxt, w_jmax_nxt;
  logic [CW-1:0]        r_dcnt, w_dcnt_nxt;
  logic                 r_busy, r_done, r_rd_en, r_acc_clr, r_wr_z;
  logic                 w_busy_nxt, w_done_nxt, w_rd_en_nxt, w_acc_clr_nxt, w_wr_z_nxt;
  logic [DATAWIDTH-1:0] r_addr_x, r_addr_y, w_addr_x_nxt, w_addr_y_nxt;
  logic [AW-1:0]        r_addr_z, w_addr_z_nxt;
  logic [AW-1:0]        w_nx_ext, w_ny_ext, w_jmin, w_jmax;

  assign w_nx_ext = {1'b0, r_nx};
  assign w_ny_ext = {1'b0, r_ny};
  // j range for the current i: max(0, i-(Ny-1)) .. min(i, Nx-1); Nx,Ny >= 1 here.
  assign w_jmin = (r_i >= w_ny_ext) ? (r_i - w_ny_ext + AW'(1)) : '0;
  assign w_jmax = (r_i < (w_nx_ext - AW'(1))) ? r_i : (w_nx_ext - AW'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Outputs are computed here one cycle ahead and registered, so each strobe
  // lines up with the state cycle it belongs to.
  always_comb begin
    w_state_nxt   = r_state;
    w_nx_nxt      = r_nx;
    w_ny_nxt      = r_ny;
    w_out_len_nxt = r_out_len;
    w_i_nxt       = r_i;
    w_j_nxt       = r_j;
    w_jmax_nxt    = r_jmax;
    w_dcnt_nxt    = r_dcnt;
    w_busy_nxt    = r_busy;
    w_addr_x_nxt  = r_addr_x;
    w_addr_y_nxt  = r_addr_y;
    w_addr_z_nxt  = r_addr_z;
    w_done_nxt    = 1'b0;
    w_rd_en_nxt   = 1'b0;
    w_acc_clr_nxt = 1'b0;
    w_wr_z_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_state_nxt = LOAD;
          w_busy_nxt  = 1'b1;
          w_nx_nxt    = size_x_i;
          w_ny_nxt    = size_y_i;
        end
      end
      LOAD: begin
        w_out_len_nxt = w_nx_ext + w_ny_ext - AW'(1);
        w_i_nxt       = '0;
        if (r_nx == '0 || r_ny == '0) begin
          w_state_nxt = DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = SETUP;
        end
      end
      SETUP: begin
        w_state_nxt   = INNER;
        w_j_nxt       = w_jmin;
        w_jmax_nxt    = w_jmax;
        w_addr_x_nxt  = w_jmin[DATAWIDTH-1:0];
        w_addr_y_nxt  = DATAWIDTH'(r_i - w_jmin);
        w_rd_en_nxt   = 1'b1;
        w_acc_clr_nxt = 1'b1;
      end
      INNER: begin
        if (r_j == r_jmax) begin
          w_state_nxt = DRAIN;
          w_dcnt_nxt  = '0;
        end else begin
          w_j_nxt      = r_j + AW'(1);
          w_addr_x_nxt = DATAWIDTH'(r_j + AW'(1));
          w_addr_y_nxt = DATAWIDTH'(r_i - r_j - AW'(1));
          w_rd_en_nxt  = 1'b1;
        end
      end
      DRAIN: begin
        // Wait for the delayed MAC strobes to retire before writing z.
        if (r_dcnt == CW'(MEM_LAT - 1)) begin
          w_state_nxt  = WRITE;
          w_wr_z_nxt   = 1'b1;
          w_addr_z_nxt = r_i;
        end else begin
          w_dcnt_nxt = r_dcnt + CW'(1);
        end
      end
      WRITE: begin
        if (r_i == r_out_len - AW'(1)) begin
          w_state_nxt = DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = SETUP;
          w_i_nxt     = r_i + AW'(1);
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_nx      <= '0;
      r_ny      <= '0;
      r_out_len <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_jmax    <= '0;
      r_dcnt    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_en   <= 1'b0;
      r_acc_clr <= 1'b0;
      r_wr_z    <= 1'b0;
      r_addr_x  <= '0;
      r_addr_y  <= '0;
      r_addr_z  <= '0;
    end else begin
      r_nx      <= w_nx_nxt;
      r_ny      <= w_ny_nxt;
      r_out_len <= w_out_len_nxt;
      r_i       <= w_i_nxt;
      r_j       <= w_j_nxt;
      r_jmax    <= w_jmax_nxt;
      r_dcnt    <= w_dcnt_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_rd_en   <= w_rd_en_nxt;
      r_acc_clr <= w_acc_clr_nxt;
      r_wr_z    <= w_wr_z_nxt;
      r_addr_x  <= w_addr_x_nxt;
      r_addr_y  <= w_addr_y_nxt;
      r_addr_z  <= w_addr_z_nxt;
    end
  end

  // rd_en doubles as the internal accumulate-enable.
  conv_strobe_delay #(
    .DEPTH(MEM_LAT)
  ) u_strobe_delay (
    .clk       (clk),
    .rstn      (rstn),
    .i_strb_dat({r_rd_en, r_acc_clr}),
    .o_strb_dat({mac_en_o, mac_clr_o})
  );

  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign rd_en_o  = r_rd_en;
  assign wr_z_o   = r_wr_z;
  assign addr_x_o = r_addr_x;
  assign addr_y_o = r_addr_y;
  assign addr_z_o = r_addr_z;

endmodule

// File: tb/tb_convolution_ctrl.sv
module tb_convolution_ctrl;
  localparam int DW = 5;
  localparam int ML = 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start_i;
  logic [DW-1:0] size_x_i, size_y_i;
  logic          busy_o, done_o, rd_en_o, mac_clr_o, mac_en_o, wr_z_o;
  logic [DW-1:0] addr_x_o, addr_y_o;
  logic [DW:0]   addr_z_o;

  convolution_ctrl #(.DATAWIDTH(DW), .MEM_LAT(ML)) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i),
    .size_x_i(size_x_i), .size_y_i(size_y_i),
    .busy_o(busy_o), .done_o(done_o),
    .addr_x_o(addr_x_o), .addr_y_o(addr_y_o), .rd_en_o(rd_en_o),
    .mac_clr_o(mac_clr_o), .mac_en_o(mac_en_o),
    .wr_z_o(wr_z_o), .addr_z_o(addr_z_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          rd;
    logic [DW-1:0] ax;
    logic [DW-1:0] ay;
    logic          clr;
    logic          en;
    logic          wr;
    logic [DW:0]   az;
  } obs_t;

  obs_t exp_q[$];
  int n_chk = 0, n_fail = 0;
  int c_en, c_clr, c_wr, c_rd, c_busy, done_at, max_ay, idx;
  logic [DW-1:0] m_ax = '0, m_ay = '0;
  logic [DW:0]   m_az = '0;

  function automatic obs_t dut_obs();
    obs_t o;
    o.busy = busy_o;  o.done = done_o;  o.rd = rd_en_o;
    o.ax = addr_x_o;  o.ay = addr_y_o;
    o.clr = mac_clr_o; o.en = mac_en_o; o.wr = wr_z_o; o.az = addr_z_o;
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected cycle-by-cycle timeline of one run, derived from the
  // convolution index ranges rather than from any state machine.
  task automatic build(input int nx, input int ny);
    obs_t t[$];
    obs_t e;
    int   en_pos[$], clr_pos[$];
    int   lo, hi;
    e = '0;
    e.ax = m_ax; e.ay = m_ay; e.az = m_az;
    e.busy = 1'b1;
    t.push_back(e);                               // size/length load
    if (nx != 0 && ny != 0) begin
      for (int i = 0; i < nx + ny - 1; i++) begin
        lo = (i - (ny - 1) > 0) ? i - (ny - 1) : 0;
        hi = (i < nx - 1) ? i : nx - 1;
        e.rd = 1'b0;
        t.push_back(e);                           // per-sample setup
        for (int j = lo; j <= hi; j++) begin
          e.rd = 1'b1; e.ax = DW'(j); e.ay = DW'(i - j);
          t.push_back(e);
          en_pos.push_back(t.size() - 1 + ML);    // product arrives ML later
          if (j == lo) clr_pos.push_back(t.size() - 1 + ML);
        end
        e.rd = 1'b0;
        repeat (ML) t.push_back(e);
        e.wr = 1'b1; e.az = (DW+1)'(i);
        t.push_back(e);
        e.wr = 1'b0;
      end
    end
    e.busy = 1'b0; e.done = 1'b1;
    t.push_back(e);
    e.done = 1'b0;
    repeat (3) t.push_back(e);                    // quiet idle afterwards
    foreach (en_pos[k])  t[en_pos[k]].en = 1'b1;
    foreach (clr_pos[k]) t[clr_pos[k]].clr = 1'b1;
    m_ax = e.ax; m_ay = e.ay; m_az = e.az;
    foreach (t[k]) exp_q.push_back(t[k]);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t e, a;
      e = exp_q.pop_front();
      a = dut_obs();
      check($sformatf("cycle%0d", idx), 64'(a), 64'(e));
      c_en += int'(a.en); c_clr += int'(a.clr); c_wr += int'(a.wr);
      c_rd += int'(a.rd); c_busy += int'(a.busy);
      if (a.done) done_at = idx;
      if (a.rd && int'(a.ay) > max_ay) max_ay = int'(a.ay);
      idx++;
    end
  end

  task automatic run(input int nx, input int ny, input bit glitch, input int x_busy,
                     input int x_en, input int x_clr, input int x_wr, input int x_done);
    string tag;
    tag = $sformatf("run%0dx%0d", nx, ny);
    @(negedge clk); #1;
    c_en = 0; c_clr = 0; c_wr = 0; c_rd = 0; c_busy = 0; done_at = -1; max_ay = 0; idx = 0;
    size_x_i = DW'(nx); size_y_i = DW'(ny); start_i = 1'b1;
    build(nx, ny);
    for (int k = 1; k < 5000 && exp_q.size() > 0; k++) begin
      @(negedge clk); #1;
      // Inputs driven at iteration k are sampled in timeline entry k-1.
      start_i = glitch && (k == 3 || k == x_done + 1);
      if (k == 1) begin size_x_i = DW'(nx + 7); size_y_i = DW'(ny + 3); end
    end
    check({tag, "_timeout"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    check({tag, "_busy_cycles"}, 64'(c_busy), 64'(x_busy));
    check({tag, "_mac_en"}, 64'(c_en), 64'(x_en));
    check({tag, "_mac_clr"}, 64'(c_clr), 64'(x_clr));
    check({tag, "_wr_z"}, 64'(c_wr), 64'(x_wr));
    check({tag, "_done_at"}, 64'(done_at), 64'(x_done));
    check({tag, "_rd_vs_en"}, 64'(c_rd), 64'(x_en));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_wr, aborted_bad;
    rstn = 1'b0; start_i = 1'b0; size_x_i = '0; size_y_i = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(dut_obs()), 64'd0);
    #1 rstn = 1'b1;

    // busy: load + 4 samples*(setup+drain+write) + 6 inner = 19; done in the next cycle
    run(3, 2, 1'b0, 19, 6, 4, 4, 19);
    run(1, 1, 1'b0, 5, 1, 1, 1, 5);
    run(0, 5, 1'b0, 1, 0, 0, 0, 1);
    // 961 products, 61 samples: busy = 1 + 61*3 + 961
    run(31, 31, 1'b0, 1145, 961, 61, 61, 1145);
    check("n31_max_addr_y", 64'(max_ay), 64'd30);
    check("n31_last_addr_z", 64'(addr_z_o), 64'd60);
    // start pulsed in an INNER cycle and in the DONE cycle, sizes disturbed
    run(3, 2, 1'b1, 19, 6, 4, 4, 19);

    // Abort mid-INNER with reset.
    @(negedge clk); #1;
    size_x_i = 5'd4; size_y_i = 5'd3; start_i = 1'b1;
    @(negedge clk); #1;
    start_i = 1'b0;
    seen_wr = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (wr_z_o) seen_wr = 1'b1;
      if (seen_wr && rd_en_o) break;
    end
    check("abort_in_inner", 64'(rd_en_o), 64'd1);
    #1 rstn = 1'b0;
    #1 check("abort_outputs_zero", 64'(dut_obs()), 64'd0);
    m_ax = '0; m_ay = '0; m_az = '0;
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
    aborted_bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done_o || busy_o || wr_z_o) aborted_bad = 1'b1;
    end
    check("abort_no_done", 64'(aborted_bad), 64'd0);
    run(2, 2, 1'b0, 14, 4, 3, 3, 14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
